controle_multiciclo: RTL and testbench

- Multicycle MIPS control unit. It sits directly upstream of ula32 and drives ULAcontrole/addSub plus all datapath enables and muxes.
- Opcode and funct come from the instruction register. zero and overflow come back from ula32.
- One instruction runs as a sequence of Moore states: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; illegal instruction 3 cycles.

---
 rtl/controle_multiciclo_pkg.sv | 149 ++++++++++++++
 rtl/controle_multiciclo_if.sv | 36 +++
 rtl/controle_multiciclo_decod_funct.sv | 34 +++
 rtl/controle_multiciclo.sv | 102 ++++++++++
 tb/tb_controle_multiciclo.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, functs,
// ULA operations, datapath mux selectors and the per-state output decode.
package controle_pkg;

    typedef enum logic [3:0] {
        BUSCA,
        DECODIFICA,
        MEM_END,
        MEM_LEIT,
        MEM_WB,
        MEM_ESCR,
        EXEC_R,
        R_WB,
        ADDI_EXEC,
        ADDI_WB,
        DESVIO,
        SALTO,
        ILEGAL
    } estado_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;

    localparam logic [2:0] ULA_AND    = 3'b000;
    localparam logic [2:0] ULA_OR     = 3'b001;
    localparam logic [2:0] ULA_ADDSUB = 3'b010;
    localparam logic [2:0] ULA_SLT    = 3'b011;
    localparam logic [2:0] ULA_NOR    = 3'b100;

    localparam logic       SRCA_PC      = 1'b0;
    localparam logic       SRCA_REG     = 1'b1;
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_4       = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCSRC_ULA    = 2'b00;
    localparam logic [1:0] PCSRC_ULAOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic       IORD_PC      = 1'b0;
    localparam logic       IORD_ULAOUT  = 1'b1;
    localparam logic       REGDST_RT    = 1'b0;
    localparam logic       REGDST_RD    = 1'b1;
    localparam logic       M2R_ULAOUT   = 1'b0;
    localparam logic       M2R_MDR      = 1'b1;
    localparam logic       ULA_ADD      = 1'b0;
    localparam logic       ULA_SUB      = 1'b1;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       ula_src_a;
        logic [1:0] ula_src_b;
        logic [1:0] pc_src;
        logic [2:0] ula_controle;
        logic       add_sub;
        logic       excecao;
        logic       instr_fim;
    } sinais_t;

    // Moore decode of one state; ula_r/add_sub_r only matter in EXEC_R, ovf only in the WB states.
    function automatic sinais_t saidas_do_estado(estado_t e, logic [2:0] ula_r,
                                                 logic add_sub_r, logic ovf);
        sinais_t s;
        s              = '0;
        s.ula_controle = ULA_ADDSUB;
        s.add_sub      = ULA_ADD;
        case (e)
            BUSCA: begin
                s.ula_src_a = SRCA_PC;
                s.ula_src_b = SRCB_4;
                s.pc_src    = PCSRC_ULA;
                s.pc_write  = 1'b1;
                s.ir_write  = 1'b1;
            end
            DECODIFICA: begin
                s.ula_src_a = SRCA_PC;
                s.ula_src_b = SRCB_IMM_SH2;
            end
            MEM_END, ADDI_EXEC: begin
                s.ula_src_a = SRCA_REG;
                s.ula_src_b = SRCB_IMM;
            end
            MEM_LEIT: s.i_or_d = IORD_ULAOUT;
            MEM_WB: begin
                s.reg_dst    = REGDST_RT;
                s.mem_to_reg = M2R_MDR;
                s.reg_write  = 1'b1;
                s.instr_fim  = 1'b1;
            end
            MEM_ESCR: begin
                s.i_or_d    = IORD_ULAOUT;
                s.mem_write = 1'b1;
                s.instr_fim = 1'b1;
            end
            EXEC_R: begin
                s.ula_src_a    = SRCA_REG;
                s.ula_src_b    = SRCB_B;
                s.ula_controle = ula_r;
                s.add_sub      = add_sub_r;
            end
            R_WB, ADDI_WB: begin
                s.reg_dst    = (e == R_WB) ? REGDST_RD : REGDST_RT;
                s.mem_to_reg = M2R_ULAOUT;
                s.instr_fim  = 1'b1;
                s.reg_write  = ~ovf;
                s.excecao    = ovf;
            end
            DESVIO: begin
                s.ula_src_a     = SRCA_REG;
                s.ula_src_b     = SRCB_B;
                s.add_sub       = ULA_SUB;
                s.pc_write_cond = 1'b1;
                s.pc_src        = PCSRC_ULAOUT;
                s.instr_fim     = 1'b1;
            end
            SALTO: begin
                s.pc_write  = 1'b1;
                s.pc_src    = PCSRC_JUMP;
                s.instr_fim = 1'b1;
            end
            ILEGAL: begin
                s.excecao   = 1'b1;
                s.instr_fim = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle control unit and its datapath/ula32.
interface controle_multiciclo_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       overflow;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ula_src_a;
    logic [1:0] ula_src_b;
    logic [1:0] pc_src;
    logic [2:0] ULAcontrole;
    logic       addSub;
    logic       excecao;
    logic       instr_fim;

    modport master (
        input  opcode, funct, zero, overflow,
        output pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, ula_src_a, ula_src_b, pc_src,
               ULAcontrole, addSub, excecao, instr_fim
    );

    modport slave (
        output opcode, funct, zero, overflow,
        input  pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, ula_src_a, ula_src_b, pc_src,
               ULAcontrole, addSub, excecao, instr_fim
    );
endinterface

// File: rtl/controle_multiciclo_decod_funct.sv
// R-type funct decoder: ULA operation, add/sub select, legality and whether
// the operation traps on signed overflow.
module decod_funct
    import controle_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] ula_op_o,
    output logic       add_sub_o,
    output logic       legal_o,
    output logic       signed_op_o
);

    always_comb begin
        ula_op_o    = ULA_ADDSUB;
        add_sub_o   = ULA_ADD;
        legal_o     = 1'b1;
        signed_op_o = 1'b0;
        case (funct_i)
            F_ADD:  signed_op_o = 1'b1;
            F_ADDU: ;
            F_SUB: begin
                add_sub_o   = ULA_SUB;
                signed_op_o = 1'b1;
            end
            F_SUBU: add_sub_o = ULA_SUB;
            F_AND:  ula_op_o  = ULA_AND;
            F_OR:   ula_op_o  = ULA_OR;
            F_NOR:  ula_op_o  = ULA_NOR;
            F_SLT:  ula_op_o  = ULA_SLT;
            default: legal_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM with registered Moore outputs; enables are
// additionally gated by the asynchronous reset so they drop without a clock.
module controle_multiciclo
    import controle_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    controle_multiciclo_if.master bus
);

    estado_t estado_q, estado_d;
    logic    ovf_q, ovf_d;
    logic    eh_lw_q, eh_lw_d;
    sinais_t saida_q, saida_d;

    logic [2:0] ula_op;
    logic       add_sub;
    logic       funct_legal;
    logic       funct_signed;
    logic       unused_zero;

    // Branch resolution on zero happens in the datapath, not here.
    assign unused_zero = bus.zero;

    decod_funct u_decod_funct (
        .funct_i     (bus.funct),
        .ula_op_o    (ula_op),
        .add_sub_o   (add_sub),
        .legal_o     (funct_legal),
        .signed_op_o (funct_signed)
    );

    always_comb begin
        estado_d = estado_q;
        ovf_d    = ovf_q;
        eh_lw_d  = eh_lw_q;
        case (estado_q)
            BUSCA: begin
                estado_d = DECODIFICA;
                ovf_d    = 1'b0;
            end
            DECODIFICA: begin
                eh_lw_d = (bus.opcode == OP_LW);
                case (bus.opcode)
                    OP_LW, OP_SW: estado_d = MEM_END;
                    OP_RTYPE:     estado_d = funct_legal ? EXEC_R : ILEGAL;
                    OP_BEQ:       estado_d = DESVIO;
                    OP_ADDI:      estado_d = ADDI_EXEC;
                    OP_J:         estado_d = SALTO;
                    default:      estado_d = ILEGAL;
                endcase
            end
            MEM_END:  estado_d = eh_lw_q ? MEM_LEIT : MEM_ESCR;
            MEM_LEIT: estado_d = MEM_WB;
            EXEC_R: begin
                estado_d = R_WB;
                ovf_d    = bus.overflow & funct_signed;
            end
            ADDI_EXEC: begin
                estado_d = ADDI_WB;
                ovf_d    = bus.overflow;
            end
            MEM_WB, MEM_ESCR, R_WB, ADDI_WB, DESVIO, SALTO, ILEGAL:
                estado_d = BUSCA;
            default: estado_d = BUSCA;
        endcase
    end

    // Outputs are decoded from the next state so they are valid for the whole state.
    assign saida_d = saidas_do_estado(estado_d, ula_op, add_sub, ovf_d);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            estado_q <= BUSCA;
            ovf_q    <= 1'b0;
            eh_lw_q  <= 1'b0;
            saida_q  <= saidas_do_estado(BUSCA, ULA_ADDSUB, ULA_ADD, 1'b0);
        end else begin
            estado_q <= estado_d;
            ovf_q    <= ovf_d;
            eh_lw_q  <= eh_lw_d;
            saida_q  <= saida_d;
        end
    end

    assign bus.pc_write      = saida_q.pc_write      & rst;
    assign bus.pc_write_cond = saida_q.pc_write_cond & rst;
    assign bus.mem_write     = saida_q.mem_write     & rst;
    assign bus.ir_write      = saida_q.ir_write      & rst;
    assign bus.reg_write     = saida_q.reg_write     & rst;
    assign bus.excecao       = saida_q.excecao       & rst;
    assign bus.instr_fim     = saida_q.instr_fim     & rst;
    assign bus.i_or_d        = saida_q.i_or_d;
    assign bus.reg_dst       = saida_q.reg_dst;
    assign bus.mem_to_reg    = saida_q.mem_to_reg;
    assign bus.ula_src_a     = saida_q.ula_src_a;
    assign bus.ula_src_b     = saida_q.ula_src_b;
    assign bus.pc_src        = saida_q.pc_src;
    assign bus.ULAcontrole   = saida_q.ula_controle;
    assign bus.addSub        = saida_q.add_sub;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle expected output vectors are
// queued when an instruction is launched and compared as each state is reached.
module tb_controle_multiciclo;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       regdst;
        logic       m2r;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] pcsrc;
        logic [2:0] ulac;
        logic       addsub;
        logic       exc;
        logic       fim;
    } sig_t;

    logic clk;
    logic rst;
    controle_multiciclo_if bus ();

    controle_multiciclo dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_cmp  = 0;
    int    n_fail = 0;
    sig_t  exp_q[$];
    string tag_q[$];

    function automatic sig_t base();
        sig_t s;
        s      = '0;
        s.ulac = 3'b010;
        return s;
    endfunction

    function automatic sig_t e_busca();
        sig_t s = base();
        s.srcb = 2'b01; s.pcw = 1'b1; s.irw = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_decod();
        sig_t s = base();
        s.srcb = 2'b11;
        return s;
    endfunction

    function automatic sig_t e_imm_exec();
        sig_t s = base();
        s.srca = 1'b1; s.srcb = 2'b10;
        return s;
    endfunction

    function automatic sig_t e_mem_leit();
        sig_t s = base();
        s.iord = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_mem_wb();
        sig_t s = base();
        s.m2r = 1'b1; s.regw = 1'b1; s.fim = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_mem_escr();
        sig_t s = base();
        s.iord = 1'b1; s.memw = 1'b1; s.fim = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_exec_r(logic [2:0] ula, logic as);
        sig_t s = base();
        s.srca = 1'b1; s.srcb = 2'b00; s.ulac = ula; s.addsub = as;
        return s;
    endfunction

    function automatic sig_t e_wb(logic rd, logic ovf);
        sig_t s = base();
        s.regdst = rd; s.fim = 1'b1; s.regw = ~ovf; s.exc = ovf;
        return s;
    endfunction

    function automatic sig_t e_desvio();
        sig_t s = base();
        s.srca = 1'b1; s.addsub = 1'b1; s.pcwc = 1'b1; s.pcsrc = 2'b01; s.fim = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_salto();
        sig_t s = base();
        s.pcw = 1'b1; s.pcsrc = 2'b10; s.fim = 1'b1;
        return s;
    endfunction

    function automatic sig_t e_ilegal();
        sig_t s = base();
        s.exc = 1'b1; s.fim = 1'b1;
        return s;
    endfunction

    function automatic sig_t observed();
        sig_t s;
        s.pcw    = bus.pc_write;    s.pcwc  = bus.pc_write_cond;
        s.iord   = bus.i_or_d;      s.memw  = bus.mem_write;
        s.irw    = bus.ir_write;    s.regdst = bus.reg_dst;
        s.m2r    = bus.mem_to_reg;  s.regw  = bus.reg_write;
        s.srca   = bus.ula_src_a;   s.srcb  = bus.ula_src_b;
        s.pcsrc  = bus.pc_src;      s.ulac  = bus.ULAcontrole;
        s.addsub = bus.addSub;      s.exc   = bus.excecao;
        s.fim    = bus.instr_fim;
        return s;
    endfunction

    task automatic push(input string t, input sig_t s);
        exp_q.push_back(s);
        tag_q.push_back(t);
    endtask

    task automatic check_now();
        sig_t  a, e;
        string t;
        a = observed();
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %h expected <none>", a);
            return;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        assert (a === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", t, a, e);
        end
        $display("cycle %s observed %h", t, a);
    endtask

    task automatic check_reset(input string t);
        logic [6:0] en;
        en = {bus.pc_write, bus.pc_write_cond, bus.mem_write, bus.ir_write,
              bus.reg_write, bus.excecao, bus.instr_fim};
        n_cmp++;
        assert (en === 7'b0) else begin
            n_fail++;
            $error("FAIL %s: observed enables %b expected %b", t, en, 7'b0);
        end
        $display("reset %s enables %b", t, en);
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            #1 check_now();
            @(negedge clk);
        end
    endtask

    task automatic set_in(input logic [5:0] op, input logic [5:0] fn,
                          input logic ovf, input logic z);
        bus.opcode   = op;
        bus.funct    = fn;
        bus.overflow = ovf;
        bus.zero     = z;
    endtask

    logic [5:0] r_fn  [8];
    logic [2:0] r_ula [8];
    logic       r_as  [8];
    logic       r_ovf [8];
    logic       r_exc [8];

    initial begin
        r_fn[0] = 6'b100000; r_ula[0] = 3'b010; r_as[0] = 1'b0; r_ovf[0] = 1'b0; r_exc[0] = 1'b0;
        r_fn[1] = 6'b100000; r_ula[1] = 3'b010; r_as[1] = 1'b0; r_ovf[1] = 1'b1; r_exc[1] = 1'b1;
        r_fn[2] = 6'b100001; r_ula[2] = 3'b010; r_as[2] = 1'b0; r_ovf[2] = 1'b1; r_exc[2] = 1'b0;
        r_fn[3] = 6'b100100; r_ula[3] = 3'b000; r_as[3] = 1'b0; r_ovf[3] = 1'b1; r_exc[3] = 1'b0;
        r_fn[4] = 6'b100101; r_ula[4] = 3'b001; r_as[4] = 1'b0; r_ovf[4] = 1'b0; r_exc[4] = 1'b0;
        r_fn[5] = 6'b100111; r_ula[5] = 3'b100; r_as[5] = 1'b0; r_ovf[5] = 1'b0; r_exc[5] = 1'b0;
        r_fn[6] = 6'b101010; r_ula[6] = 3'b011; r_as[6] = 1'b0; r_ovf[6] = 1'b1; r_exc[6] = 1'b0;
        r_fn[7] = 6'b100010; r_ula[7] = 3'b010; r_as[7] = 1'b1; r_ovf[7] = 1'b0; r_exc[7] = 1'b0;

        // Reset held for three cycles with lw already on the bus.
        rst = 1'b0;
        set_in(6'b100011, 6'b000000, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check_reset("reset_hold");
        end
        rst = 1'b1;

        // lw: five cycles
        push("lw_busca", e_busca());   push("lw_decod", e_decod());
        push("lw_end", e_imm_exec());  push("lw_leit", e_mem_leit());
        push("lw_wb", e_mem_wb());
        run_cycles(5);

        // sw: four cycles
        set_in(6'b101011, 6'b000000, 1'b0, 1'b0);
        push("sw_busca", e_busca());   push("sw_decod", e_decod());
        push("sw_end", e_imm_exec());  push("sw_escr", e_mem_escr());
        run_cycles(4);

        // sub with signed overflow traps; subu with overflow writes back
        set_in(6'b000000, 6'b100010, 1'b1, 1'b0);
        push("sub_busca", e_busca());  push("sub_decod", e_decod());
        push("sub_exec", e_exec_r(3'b010, 1'b1)); push("sub_wb", e_wb(1'b1, 1'b1));
        run_cycles(4);
        set_in(6'b000000, 6'b100011, 1'b1, 1'b0);
        push("subu_busca", e_busca()); push("subu_decod", e_decod());
        push("subu_exec", e_exec_r(3'b010, 1'b1)); push("subu_wb", e_wb(1'b1, 1'b0));
        run_cycles(4);

        for (int k = 0; k < 8; k++) begin
            set_in(6'b000000, r_fn[k], r_ovf[k], 1'b0);
            push("r_busca", e_busca()); push("r_decod", e_decod());
            push("r_exec", e_exec_r(r_ula[k], r_as[k])); push("r_wb", e_wb(1'b1, r_exc[k]));
            run_cycles(4);
        end

        // addi with and without overflow
        set_in(6'b001000, 6'b111111, 1'b1, 1'b0);
        push("addi_busca", e_busca()); push("addi_decod", e_decod());
        push("addi_exec", e_imm_exec()); push("addi_wb", e_wb(1'b0, 1'b1));
        run_cycles(4);
        set_in(6'b001000, 6'b000000, 1'b0, 1'b0);
        push("addi_busca", e_busca()); push("addi_decod", e_decod());
        push("addi_exec", e_imm_exec()); push("addi_wb", e_wb(1'b0, 1'b0));
        run_cycles(4);

        // beq taken and not taken share the same path; then j
        set_in(6'b000100, 6'b000000, 1'b0, 1'b1);
        push("beq1_busca", e_busca()); push("beq1_decod", e_decod()); push("beq1_desvio", e_desvio());
        run_cycles(3);
        set_in(6'b000100, 6'b000000, 1'b0, 1'b0);
        push("beq0_busca", e_busca()); push("beq0_decod", e_decod()); push("beq0_desvio", e_desvio());
        run_cycles(3);
        set_in(6'b000010, 6'b000000, 1'b0, 1'b0);
        push("j_busca", e_busca()); push("j_decod", e_decod()); push("j_salto", e_salto());
        run_cycles(3);

        // illegal opcode, then illegal R-type funct
        set_in(6'b111111, 6'b000000, 1'b0, 1'b0);
        push("ilop_busca", e_busca()); push("ilop_decod", e_decod()); push("ilop_ilegal", e_ilegal());
        run_cycles(3);
        set_in(6'b000000, 6'b000111, 1'b0, 1'b0);
        push("ilfn_busca", e_busca()); push("ilfn_decod", e_decod()); push("ilfn_ilegal", e_ilegal());
        run_cycles(3);

        // Async reset in EXEC_R of an overflowing add
        set_in(6'b000000, 6'b100000, 1'b1, 1'b0);
        push("rst_busca", e_busca()); push("rst_decod", e_decod());
        run_cycles(2);
        push("rst_exec", e_exec_r(3'b010, 1'b0));
        #1 check_now();
        #1 rst = 1'b0;
        #1 check_reset("async_exec_r");
        @(negedge clk);
        rst = 1'b1;
        set_in(6'b000000, 6'b100000, 1'b0, 1'b0);
        push("post_busca", e_busca()); push("post_decod", e_decod());
        push("post_exec", e_exec_r(3'b010, 1'b0)); push("post_wb", e_wb(1'b1, 1'b0));
        run_cycles(4);

        // Async reset while R_WB drives excecao: it must fall without a clock edge
        set_in(6'b000000, 6'b100010, 1'b1, 1'b0);
        push("rwb_busca", e_busca()); push("rwb_decod", e_decod());
        push("rwb_exec", e_exec_r(3'b010, 1'b1)); push("rwb_wb", e_wb(1'b1, 1'b1));
        run_cycles(3);
        #1 check_now();
        #1 rst = 1'b0;
        #1 check_reset("async_r_wb");
        @(negedge clk);
        rst = 1'b1;
        set_in(6'b000010, 6'b000000, 1'b0, 1'b0);
        push("end_busca", e_busca()); push("end_decod", e_decod()); push("end_salto", e_salto());
        run_cycles(3);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
